// File: rtl/markov_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// markov_pipeline_sequencer
//
// Sequences a three-level processing tree:
//   four learners (AA, AB, BA, BB) -> two first-level merges (A, B)
//   -> one second-level merge.
// Each unit gets a single-cycle start pulse. Its completion is latched from
// the cycle after that pulse onward. A first-level merge starts as soon as
// both of its learners are finished, so merge A can run while learners BA/BB
// are still busy. A per-stage watchdog stops a run that stalls.
//
// Ports
//   clk           : clock, rising edge
//   reset         : asynchronous reset, active low
//   go            : run request, accepted only in IDLE and only with abort=0
//   abort         : cancel the current run; error is left unchanged
//   learn_done    : learner completions  {BB, BA, AB, AA}, pulse or level
//   merge1_done   : first-merge completions {B, A}, pulse or level
//   merge2_done   : second-merge completion
//   learn_start   : single-cycle start pulses to the learners
//   merge1_start  : single-cycle start pulses to the first-merge units
//   merge2_start  : single-cycle start pulse to the second merge
//   busy          : high in every state except IDLE
//   done          : single-cycle pulse when a run completes successfully
//   error         : sticky watchdog-expiry flag, cleared by the next accepted go
//   stage         : current state, 0=IDLE 1=LEARN 2=MERGE1 3=MERGE2
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module markov_pipeline_sequencer #(
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       abort,
  input  logic [3:0] learn_done,
  input  logic [1:0] merge1_done,
  input  logic       merge2_done,
  output logic [3:0] learn_start,
  output logic [1:0] merge1_start,
  output logic       merge2_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] stage
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEARN  = 2'd1,
    S_MERGE1 = 2'd2,
    S_MERGE2 = 2'd3
  } state_e;

  // The watchdog fires on the cycle its count would reach TIMEOUT. As a
  // result, the state is left exactly TIMEOUT cycles after it was entered.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);

  state_e               state_q, state_d;
  logic [3:0]           lat_l_q, lat_l_d;
  logic [1:0]           lat_m1_q, lat_m1_d;
  logic [1:0]           issued_q, issued_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic [3:0]           learn_start_q, learn_start_d;
  logic [1:0]           merge1_start_q, merge1_start_d;
  logic                 merge2_start_q, merge2_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic [1:0]           pair_ready;
  logic [1:0]           new_m1;

  always_comb begin
    // NOTE: every variable written in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    state_d        = state_q;
    lat_l_d        = lat_l_q;
    lat_m1_d       = lat_m1_q;
    issued_d       = issued_q;
    wdog_d         = wdog_q;
    error_d        = error_q;
    learn_start_d  = 4'b0000;
    merge1_start_d = 2'b00;
    merge2_start_d = 1'b0;
    done_d         = 1'b0;
    pair_ready     = 2'b00;
    new_m1         = 2'b00;

    // Learner completions count only after the start cycle. The start pulse
    // is still high in that cycle, so learn_start_q marks it.
    if (state_q == S_LEARN && learn_start_q == 4'b0000) begin
      lat_l_d = lat_l_q | learn_done;
    end

    // First-merge completions count once that unit's start pulse has passed.
    if (state_q == S_LEARN || state_q == S_MERGE1) begin
      lat_m1_d = lat_m1_q | (merge1_done & issued_q & ~merge1_start_q);
    end

    case (state_q)
      S_IDLE: begin
        if (go && !abort) begin
          state_d       = S_LEARN;
          learn_start_d = 4'b1111;
          lat_l_d       = 4'b0000;
          lat_m1_d      = 2'b00;
          issued_d      = 2'b00;
          wdog_d        = '0;
          error_d       = 1'b0;
        end
      end

      S_LEARN: begin
        wdog_d     = wdog_q + WDOG_ONE;
        // The next latch value is used here so that a pair's merge starts on
        // the same edge that records its second learner finishing.
        pair_ready = {&lat_l_d[3:2], &lat_l_d[1:0]};
        new_m1     = pair_ready & ~issued_q;
        merge1_start_d = new_m1;
        issued_d       = issued_q | new_m1;
        if (&lat_l_d) begin
          state_d = S_MERGE1;
          wdog_d  = '0;
        end
      end

      S_MERGE1: begin
        wdog_d = wdog_q + WDOG_ONE;
        if (&lat_m1_d) begin
          state_d        = S_MERGE2;
          merge2_start_d = 1'b1;
          wdog_d         = '0;
        end
      end

      S_MERGE2: begin
        wdog_d = wdog_q + WDOG_ONE;
        if (merge2_done && !merge2_start_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          wdog_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort beats the watchdog, and both beat any pulse the stage logic
    // scheduled for the same edge.
    if (state_q != S_IDLE) begin
      if (abort) begin
        state_d        = S_IDLE;
        learn_start_d  = 4'b0000;
        merge1_start_d = 2'b00;
        merge2_start_d = 1'b0;
        done_d         = 1'b0;
        wdog_d         = '0;
      end else if (wdog_q == WDOG_LAST) begin
        state_d        = S_IDLE;
        learn_start_d  = 4'b0000;
        merge1_start_d = 2'b00;
        merge2_start_d = 1'b0;
        done_d         = 1'b0;
        error_d        = 1'b1;
        wdog_d         = '0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: every flop is cleared by the asynchronous reset, latches and
  // watchdog included, so no run state can survive a reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      lat_l_q        <= 4'b0000;
      lat_m1_q       <= 2'b00;
      issued_q       <= 2'b00;
      wdog_q         <= '0;
      learn_start_q  <= 4'b0000;
      merge1_start_q <= 2'b00;
      merge2_start_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples values from
      // before the edge, whatever order these statements are written in.
      state_q        <= state_d;
      lat_l_q        <= lat_l_d;
      lat_m1_q       <= lat_m1_d;
      issued_q       <= issued_d;
      wdog_q         <= wdog_d;
      learn_start_q  <= learn_start_d;
      merge1_start_q <= merge1_start_d;
      merge2_start_q <= merge2_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign learn_start  = learn_start_q;
  assign merge1_start = merge1_start_q;
  assign merge2_start = merge2_start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign stage        = state_q;

endmodule

// File: tb/tb_markov_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_markov_pipeline_sequencer
//
// Self-checking bench for markov_pipeline_sequencer with TIMEOUT=10.
//
// Each run is described by the latency of every unit: the number of cycles
// from its start pulse to its done input (0 means the unit never answers).
// An optional abort cycle and an optional reset cycle can also be given.
// From these numbers the reference model works out, with plain arithmetic,
// the cycle of every start pulse, every stage boundary, any watchdog expiry
// and the end of the run. The bench then compares all outputs every cycle.
// When noise is enabled, done inputs carry random values outside each unit's
// valid window; these values must have no effect.
// -----------------------------------------------------------------------------
module tb_markov_pipeline_sequencer;

  localparam int TO    = 10;
  localparam int NEVER = 1000000;

  logic       clk = 1'b0;
  logic       reset;
  logic       go;
  logic       abort;
  logic [3:0] learn_done;
  logic [1:0] merge1_done;
  logic       merge2_done;
  logic [3:0] learn_start;
  logic [1:0] merge1_start;
  logic       merge2_start;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] stage;

  always #5 clk = ~clk;

  markov_pipeline_sequencer #(
    .TIMEOUT_W(4),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .abort       (abort),
    .learn_done  (learn_done),
    .merge1_done (merge1_done),
    .merge2_done (merge2_done),
    .learn_start (learn_start),
    .merge1_start(merge1_start),
    .merge2_start(merge2_start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .stage       (stage)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state carried from one run to the next.
  bit pend_done = 1'b0;
  bit err_model = 1'b0;

  // Description of the next run.
  int r_l[4];
  int r_m[2];
  int r_k;
  int r_abort;   // busy cycle (local index) carrying abort=1, 0 = none
  int r_rst;     // local cycle in which reset is pulled, 0 = none
  int r_noise;   // 0 quiet, 1 random, 2 held high outside valid windows
  bit r_hold;    // go held high for the whole run

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic [3:0] e_ls, input logic [1:0] e_m1, input logic e_m2,
                           input logic e_busy, input logic e_done, input logic e_err,
                           input logic [1:0] e_stage);
    check("learn_start",  32'(learn_start),  32'(e_ls));
    check("merge1_start", 32'(merge1_start), 32'(e_m1));
    check("merge2_start", 32'(merge2_start), 32'(e_m2));
    check("busy",         32'(busy),         32'(e_busy));
    check("done",         32'(done),         32'(e_done));
    check("error",        32'(error),        32'(e_err));
    check("stage",        32'(stage),        32'(e_stage));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycle that comes lat cycles after cycle a; NEVER propagates.
  function automatic int later(input int a, input int lat);
    return (a >= NEVER || lat == 0) ? NEVER : a + lat;
  endfunction

  function automatic logic noise_bit(input int noise);
    if (noise == 2) return 1'b1;
    if (noise == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  // Done input of a unit started at cycle s with latency l, at cycle c.
  // Before and during the start cycle the value is noise; after that it is
  // low until the answer cycle, high in the answer cycle, and noise again
  // once the completion has been captured.
  function automatic logic drv(input int c, input int s, input int l, input int noise);
    if (c <= s) return noise_bit(noise);
    if (l == 0 || c < s + l) return 1'b0;
    if (c == s + l) return 1'b1;
    return noise_bit(noise);
  endfunction

  task automatic idle(input int n, input int noise);
    int sel;
    for (int i = 0; i < n; i++) begin
      step();
      check_all(4'h0, 2'b00, 1'b0, 1'b0, pend_done, err_model, 2'd0);
      pend_done = 1'b0;
      // go with abort, or abort alone, must both leave the DUT in IDLE.
      sel = (noise == 1) ? $urandom_range(0, 2) : 0;
      go          = (sel == 2);
      abort       = (sel != 0);
      learn_done  = {noise_bit(noise), noise_bit(noise), noise_bit(noise), noise_bit(noise)};
      merge1_done = {noise_bit(noise), noise_bit(noise)};
      merge2_done = noise_bit(noise);
    end
  endtask

  // Local cycle 0 is the IDLE cycle in which go is sampled; LEARN is entered
  // at cycle 1. end_c is the first IDLE cycle after the run.
  task automatic do_run();
    int ld[4];
    int m1s[2];
    int md[2];
    int e1, e2, d2, end_c;
    bit to, ab;
    for (int i = 0; i < 4; i++) ld[i] = later(1, r_l[i]);
    m1s[0] = later(mx(ld[0], ld[1]), 1);
    m1s[1] = later(mx(ld[2], ld[3]), 1);
    e1     = mx(m1s[0], m1s[1]);
    md[0]  = later(m1s[0], r_m[0]);
    md[1]  = later(m1s[1], r_m[1]);
    e2     = later(mx(md[0], md[1]), 1);
    d2     = later(e2, r_k);

    // A stage that lasts TO cycles or more is ended by the watchdog,
    // exactly TO cycles after the stage was entered.
    to = 1'b1;
    if (e1 - 1 >= TO)          end_c = 1 + TO;
    else if (e2 - e1 >= TO)    end_c = e1 + TO;
    else if (d2 - e2 + 1 >= TO) end_c = e2 + TO;
    else begin
      end_c = d2 + 1;
      to    = 1'b0;
    end
    ab = 1'b0;
    if (r_abort > 0 && r_abort + 1 <= end_c) begin
      end_c = r_abort + 1;
      ab    = 1'b1;
      to    = 1'b0;
    end

    for (int c = 0; c < end_c; c++) begin
      step();
      if (c == 0) begin
        check_all(4'h0, 2'b00, 1'b0, 1'b0, pend_done, err_model, 2'd0);
        pend_done = 1'b0;
      end else begin
        check_all((c == 1) ? 4'hF : 4'h0,
                  {c == m1s[1], c == m1s[0]},
                  c == e2, 1'b1, 1'b0, 1'b0,
                  (c < e1) ? 2'd1 : ((c < e2) ? 2'd2 : 2'd3));
      end
      go    = (c == 0) ? 1'b1 : (r_hold ? 1'b1 : (r_noise == 1 ? 1'($urandom_range(0, 1)) : 1'b0));
      abort = (c != 0) && (c == r_abort);
      for (int i = 0; i < 4; i++) learn_done[i] = drv(c, 1, r_l[i], r_noise);
      for (int p = 0; p < 2; p++) merge1_done[p] = drv(c, m1s[p], r_m[p], r_noise);
      merge2_done = drv(c, e2, r_k, r_noise);

      if (r_rst > 0 && c == r_rst) begin
        #2 reset = 1'b0;
        #1;
        check_all(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        go    = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset     = 1'b1;
        pend_done = 1'b0;
        err_model = 1'b0;
        return;
      end
    end
    pend_done = !to && !ab;
    err_model = to;
  endtask

  task automatic set_run(input int l0, input int l1, input int l2, input int l3,
                         input int m0, input int m1, input int k,
                         input int abort_c, input int rst_c, input int noise, input bit hold);
    r_l[0] = l0; r_l[1] = l1; r_l[2] = l2; r_l[3] = l3;
    r_m[0] = m0; r_m[1] = m1; r_k = k;
    r_abort = abort_c; r_rst = rst_c; r_noise = noise; r_hold = hold;
  endtask

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 15);
    return (r == 0) ? 0 : (r % 9) + 1;
  endfunction

  initial begin
    reset       = 1'b0;
    go          = 1'b1;
    abort       = 1'b0;
    learn_done  = 4'hF;
    merge1_done = 2'b11;
    merge2_done = 1'b1;

    // Reset state, with active inputs held.
    repeat (3) @(posedge clk);
    #1;
    check_all(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(3, 0);

    // Reference timeline: starts at 1, 7, 9, 14; done at 21; busy 1..20.
    set_run(4, 5, 6, 7, 5, 4, 6, 0, 0, 0, 1'b0);
    do_run();
    idle(2, 0);

    // Learner BB never answers: watchdog in LEARN; the next go clears error.
    set_run(2, 3, 1, 0, 1, 1, 1, 0, 0, 1, 1'b0);
    do_run();
    idle(2, 1);
    set_run(1, 2, 2, 1, 2, 2, 2, 0, 0, 1, 1'b0);
    do_run();
    idle(1, 0);

    // Abort in MERGE1 after merge A has finished and merge B has not.
    set_run(1, 1, 3, 3, 1, 0, 1, 7, 0, 1, 1'b0);
    do_run();
    idle(2, 0);

    // Done inputs held high before and during the run.
    idle(3, 2);
    set_run(1, 1, 1, 1, 2, 2, 2, 0, 0, 2, 1'b0);
    do_run();
    idle(2, 0);

    // go held high, single-cycle responders: two back-to-back runs.
    set_run(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1'b1);
    do_run();
    do_run();
    idle(2, 0);

    // Reset pulled during MERGE2, then a quiet bus.
    set_run(1, 1, 1, 1, 1, 1, 8, 0, 8, 1, 1'b0);
    do_run();
    idle(4, 0);

    // Random runs with noise, random gaps, aborts and watchdog expiries.
    for (int n = 0; n < 40; n++) begin
      set_run(rand_lat(), rand_lat(), rand_lat(), rand_lat(), rand_lat(), rand_lat(),
              rand_lat(), ($urandom_range(0, 5) == 0) ? $urandom_range(1, 25) : 0,
              0, 1, 1'($urandom_range(0, 1)));
      if (r_l[0] == 0 && r_l[1] == 0) r_l[0] = 3;
      do_run();
      idle($urandom_range(0, 3), 1);
    end
    idle(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
